// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multi-cycle RISC-V control FSM.
package riscv_ctrl_pkg;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEM_RD, S_MEM_WR, S_WB_MEM,
      S_EXEC_R, S_EXEC_I, S_WB_ALU, S_BRANCH, S_TRAP
   } state_e;
endpackage

// File: rtl/alu_sub_decode.sv
// alu_sub_decode: maps {is_imm, funct3, funct7_5} to an ALU control code and a legality flag.
module alu_sub_decode
   import riscv_ctrl_pkg::*;
(
   input  logic       is_imm_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_5_i,
   output logic [3:0] alu_ctrl_o,
   output logic       valid_o
);
   // For OP-IMM, bit 30 is immediate data except on shifts, where 1 would mean srai.
   always_comb begin
      alu_ctrl_o = ALU_ADD;
      valid_o    = 1'b0;
      case (funct3_i)
         3'b000: begin
            alu_ctrl_o = (!is_imm_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
            valid_o    = 1'b1;
         end
         3'b100: begin
            alu_ctrl_o = ALU_XOR;
            valid_o    = is_imm_i || !funct7_5_i;
         end
         3'b101: begin
            alu_ctrl_o = ALU_SRL;
            valid_o    = !funct7_5_i;
         end
         3'b110: begin
            alu_ctrl_o = ALU_OR;
            valid_o    = is_imm_i || !funct7_5_i;
         end
         3'b111: begin
            alu_ctrl_o = ALU_AND;
            valid_o    = is_imm_i || !funct7_5_i;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer driving all datapath strobes,
// with memory handshake timeout and sticky trap flags.
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int ENABLE_ITYPE = 1,
   parameter int MEM_TIMEOUT  = 15,
   parameter int ALUC_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic              funct7_5,
   input  logic              alu_zero,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic              ir_write,
   output logic              pc_write,
   output logic              pc_src,
   output logic              alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [ALUC_W-1:0] alu_ctrl,
   output logic              reg_write,
   output logic              wb_sel,
   output logic              retire,
   output logic              illegal,
   output logic              bus_err
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   state_e        state_q, state_d;
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic          illegal_q, illegal_d, bus_err_q, bus_err_d;
   logic [3:0]    dec_ctrl, aluc;
   logic          dec_valid, mem_st, timeout;
   logic          req, we, irw, pcw, pcs, srca, rw, wbs, ret;
   logic [1:0]    srcb;

   alu_sub_decode u_alu_dec (
      .is_imm_i   (state_q == S_EXEC_I),
      .funct3_i   (funct3),
      .funct7_5_i (funct7_5),
      .alu_ctrl_o (dec_ctrl),
      .valid_o    (dec_valid)
   );

   always_comb begin
      mem_st    = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
      timeout   = mem_st && !mem_ready && (wcnt_q == CW'(MEM_TIMEOUT));
      wcnt_d    = (mem_st && !mem_ready) ? wcnt_q + CW'(1) : '0;
      state_d   = state_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      req       = 1'b0;
      we        = 1'b0;
      irw       = 1'b0;
      pcw       = 1'b0;
      pcs       = 1'b0;
      srca      = 1'b0;
      srcb      = SRCB_RS2;
      aluc      = ALU_AND;
      rw        = 1'b0;
      wbs       = 1'b0;
      ret       = 1'b0;
      case (state_q)
         S_FETCH: begin
            req     = 1'b1;
            srcb    = SRCB_FOUR;
            aluc    = ALU_ADD;
            irw     = mem_ready;
            pcw     = mem_ready;
            state_d = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            srcb      = SRCB_IMM;
            aluc      = ALU_ADD;
            state_d   = (opcode == OP_LOAD || opcode == OP_STORE)   ? S_MEMADR :
                        (opcode == OP_R)                            ? S_EXEC_R :
                        (opcode == OP_IMM && ENABLE_ITYPE != 0)     ? S_EXEC_I :
                        (opcode == OP_BRANCH && funct3 == 3'b000)   ? S_BRANCH : S_TRAP;
            illegal_d = illegal_q || (state_d == S_TRAP);
         end
         S_MEMADR: begin
            srca    = 1'b1;
            srcb    = SRCB_IMM;
            aluc    = ALU_ADD;
            state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            req     = 1'b1;
            state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
         end
         S_MEM_WR: begin
            req     = 1'b1;
            we      = 1'b1;
            ret     = mem_ready;
            state_d = mem_ready ? S_FETCH : S_MEM_WR;
         end
         S_WB_MEM: begin
            rw      = 1'b1;
            wbs     = 1'b1;
            ret     = 1'b1;
            state_d = S_FETCH;
         end
         S_EXEC_R, S_EXEC_I: begin
            srca      = 1'b1;
            srcb      = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
            aluc      = dec_ctrl;
            state_d   = dec_valid ? S_WB_ALU : S_TRAP;
            illegal_d = illegal_q || !dec_valid;
         end
         S_WB_ALU: begin
            rw      = 1'b1;
            ret     = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            srca    = 1'b1;
            srcb    = SRCB_RS2;
            aluc    = ALU_SUB;
            pcw     = alu_zero;
            pcs     = 1'b1;
            ret     = 1'b1;
            state_d = S_FETCH;
         end
         default: ;
      endcase
      // A late mem_ready on the timeout cycle has already advanced state above.
      if (timeout) begin
         state_d   = S_TRAP;
         bus_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         wcnt_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Every output is forced low while reset is held, including mid-access.
   assign mem_req   = req && !rst;
   assign mem_we    = we && !rst;
   assign ir_write  = irw && !rst;
   assign pc_write  = pcw && !rst;
   assign pc_src    = pcs && !rst;
   assign alu_src_a = srca && !rst;
   assign alu_src_b = rst ? 2'b00 : srcb;
   assign alu_ctrl  = rst ? '0 : ALUC_W'(aluc);
   assign reg_write = rw && !rst;
   assign wb_sel    = wbs && !rst;
   assign retire    = ret && !rst;
   assign illegal   = illegal_q && !rst;
   assign bus_err   = bus_err_q && !rst;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven instruction vectors with a retire scoreboard plus trap/timeout sequences.
module tb_multicycle_ctrl;
   logic       clk = 1'b0, rst = 1'b1;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       funct7_5 = 1'b0, alu_zero = 1'b0, mem_ready = 1'b0;
   logic       mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a, reg_write, wb_sel, retire, illegal, bus_err;
   logic [1:0] alu_src_b;
   logic [3:0] alu_ctrl;
   logic       n_mem_req, n_mem_we, n_ir_write, n_pc_write, n_pc_src, n_alu_src_a, n_reg_write, n_wb_sel, n_retire, n_illegal, n_bus_err;
   logic [1:0] n_alu_src_b;
   logic [3:0] n_alu_ctrl;
   logic [16:0] all_o, n_all;
   logic [5:0]  strb, n_strb;
   int total = 0, bad = 0;

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, az;
      int         fd, md;
      logic [3:0] alu;
      logic [1:0] srcb;
      int         lat;
      logic       rw, wb, we, pcs;
      int         pcw;
   } vec_t;
   vec_t vt[18];
   vec_t sb[$];

   multicycle_ctrl #(.ENABLE_ITYPE(1), .MEM_TIMEOUT(4), .ALUC_W(4)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .reg_write(reg_write), .wb_sel(wb_sel),
      .retire(retire), .illegal(illegal), .bus_err(bus_err)
   );

   multicycle_ctrl #(.ENABLE_ITYPE(0), .MEM_TIMEOUT(15), .ALUC_W(4)) u_noi (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(n_mem_req), .mem_we(n_mem_we),
      .ir_write(n_ir_write), .pc_write(n_pc_write), .pc_src(n_pc_src), .alu_src_a(n_alu_src_a),
      .alu_src_b(n_alu_src_b), .alu_ctrl(n_alu_ctrl), .reg_write(n_reg_write), .wb_sel(n_wb_sel),
      .retire(n_retire), .illegal(n_illegal), .bus_err(n_bus_err)
   );

   assign all_o  = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, wb_sel, retire, illegal, bus_err};
   assign n_all  = {n_mem_req, n_mem_we, n_ir_write, n_pc_write, n_pc_src, n_alu_src_a, n_alu_src_b, n_alu_ctrl, n_reg_write, n_wb_sel, n_retire, n_illegal, n_bus_err};
   assign strb   = {mem_req, mem_we, ir_write, pc_write, reg_write, retire};
   assign n_strb = {n_mem_req, n_mem_we, n_ir_write, n_pc_write, n_reg_write, n_retire};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic rdy);
      @(negedge clk);
      mem_ready = rdy;
      #1;
   endtask

   // Reset is asserted for two cycles and released just after a rising edge,
   // so the next falling edge is cycle 1 of the first FETCH.
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk("reset outputs zero", int'(all_o), 0);
      chk("reset outputs zero (no-itype)", int'(n_all), 0);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("reset held outputs zero", int'(all_o), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int c = 0, w = 0, irs = 0, pcws = 0, rws = 0;
      bit done = 0;
      vec_t e;
      sb.push_back(v);
      while (!done && c < 60) begin
         @(negedge clk);
         c++;
         opcode = v.op;
         funct3 = v.f3;
         funct7_5 = v.f7;
         alu_zero = v.az;
         mem_ready = mem_req && (w == ((irs == 0) ? v.fd : v.md));
         w = (mem_req && !mem_ready) ? w + 1 : 0;
         #1;
         if (c == v.fd + 3) begin
            chk({v.name, " alu_ctrl"}, int'(alu_ctrl), int'(v.alu));
            chk({v.name, " alu_src_b"}, int'(alu_src_b), int'(v.srcb));
            chk({v.name, " alu_src_a"}, int'(alu_src_a), 1);
         end
         irs += int'(ir_write);
         pcws += int'(pc_write);
         rws += int'(reg_write);
         if (retire) begin
            done = 1;
            e = sb.pop_front();
            chk({e.name, " latency"}, c, e.lat);
            chk({e.name, " reg_write at retire"}, int'(reg_write), int'(e.rw));
            chk({e.name, " wb_sel at retire"}, int'(wb_sel), int'(e.wb));
            chk({e.name, " mem_we at retire"}, int'(mem_we), int'(e.we));
            chk({e.name, " pc_src at retire"}, int'(pc_src), int'(e.pcs));
            chk({e.name, " ir_write count"}, irs, 1);
            chk({e.name, " pc_write count"}, pcws, e.pcw);
            chk({e.name, " reg_write count"}, rws, int'(e.rw));
            chk({e.name, " no flags"}, int'({illegal, bus_err}), 0);
         end
      end
      if (!done) begin
         chk({v.name, " retire within budget"}, 0, 1);
         void'(sb.pop_front());
      end
   endtask

   initial begin
      vt[0]  = '{"add",   7'h33, 3'b000, 1'b0, 1'b0, 0, 0, 4'b0010, 2'b00, 4,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vt[1]  = '{"sub",   7'h33, 3'b000, 1'b1, 1'b0, 0, 0, 4'b0110, 2'b00, 4,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vt[2]  = '{"srl",   7'h33, 3'b101, 1'b0, 1'b0, 0, 0, 4'b0101, 2'b00, 4,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vt[3]  = '{"xor",   7'h33, 3'b100, 1'b0, 1'b0, 1, 0, 4'b0011, 2'b00, 5,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vt[4]  = '{"or",    7'h33, 3'b110, 1'b0, 1'b0, 0, 0, 4'b0001, 2'b00, 4,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vt[5]  = '{"and",   7'h33, 3'b111, 1'b0, 1'b0, 0, 0, 4'b0000, 2'b00, 4,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vt[6]  = '{"addi",  7'h13, 3'b000, 1'b1, 1'b0, 0, 0, 4'b0010, 2'b10, 4,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vt[7]  = '{"xori",  7'h13, 3'b100, 1'b1, 1'b0, 0, 0, 4'b0011, 2'b10, 4,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vt[8]  = '{"srli",  7'h13, 3'b101, 1'b0, 1'b0, 0, 0, 4'b0101, 2'b10, 4,  1'b1, 1'b0, 1'b0, 1'b0, 1};
      vt[9]  = '{"lw_d3", 7'h03, 3'b010, 1'b0, 1'b0, 3, 3, 4'b0010, 2'b10, 11, 1'b1, 1'b1, 1'b0, 1'b0, 1};
      vt[10] = '{"lw",    7'h03, 3'b010, 1'b0, 1'b0, 0, 0, 4'b0010, 2'b10, 5,  1'b1, 1'b1, 1'b0, 1'b0, 1};
      vt[11] = '{"lw_d4", 7'h03, 3'b010, 1'b0, 1'b0, 0, 4, 4'b0010, 2'b10, 9,  1'b1, 1'b1, 1'b0, 1'b0, 1};
      vt[12] = '{"sw",    7'h23, 3'b010, 1'b0, 1'b0, 0, 0, 4'b0010, 2'b10, 4,  1'b0, 1'b0, 1'b1, 1'b0, 1};
      vt[13] = '{"sw_d",  7'h23, 3'b010, 1'b0, 1'b0, 2, 1, 4'b0010, 2'b10, 7,  1'b0, 1'b0, 1'b1, 1'b0, 1};
      vt[14] = '{"sw_d4", 7'h23, 3'b010, 1'b0, 1'b0, 0, 4, 4'b0010, 2'b10, 8,  1'b0, 1'b0, 1'b1, 1'b0, 1};
      vt[15] = '{"beq_t", 7'h63, 3'b000, 1'b0, 1'b1, 0, 0, 4'b0110, 2'b00, 3,  1'b0, 1'b0, 1'b0, 1'b1, 2};
      vt[16] = '{"beq_n", 7'h63, 3'b000, 1'b0, 1'b0, 0, 0, 4'b0110, 2'b00, 3,  1'b0, 1'b0, 1'b0, 1'b1, 1};
      vt[17] = '{"beq_d", 7'h63, 3'b000, 1'b0, 1'b1, 2, 0, 4'b0110, 2'b00, 5,  1'b0, 1'b0, 1'b0, 1'b1, 2};

      apply_reset();
      foreach (vt[i]) run_vec(vt[i]);

      // Unknown opcode: trap after DECODE, strobes stay low even with mem_ready high.
      apply_reset();
      opcode = 7'h7F;
      funct3 = 3'b000;
      cyc(1'b1);
      cyc(1'b1);
      chk("illop illegal cycle2", int'(illegal), 0);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1);
         chk("illop illegal sticky", int'(illegal), 1);
         chk("illop strobes low", int'({strb, pc_src, wb_sel}), 0);
      end
      apply_reset();
      cyc(1'b0);
      chk("illop cleared by rst", int'({illegal, bus_err, mem_req}), 1);

      // OP-IMM with the I-type path disabled traps only in the second instance.
      apply_reset();
      opcode = 7'h13;
      funct3 = 3'b000;
      funct7_5 = 1'b0;
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b1);
      chk("noi addi illegal", int'(n_illegal), 1);
      chk("noi addi strobes low", int'(n_strb), 0);
      chk("itype addi legal", int'(illegal), 0);
      cyc(1'b1);
      chk("itype addi retire", int'(retire), 1);
      chk("noi addi no retire", int'(n_retire), 0);

      // Unsupported R-type funct3 traps out of EXEC.
      apply_reset();
      opcode = 7'h33;
      funct3 = 3'b001;
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b1);
      chk("sll not yet illegal", int'(illegal), 0);
      cyc(1'b1);
      chk("sll illegal", int'(illegal), 1);
      chk("sll no writeback", int'(strb), 0);

      // Branch with funct3 other than beq traps in DECODE.
      apply_reset();
      opcode = 7'h63;
      funct3 = 3'b001;
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b1);
      chk("bne illegal", int'(illegal), 1);

      // Store with mem_ready stuck low: four counted waits, then the timeout cycle.
      apply_reset();
      opcode = 7'h23;
      funct3 = 3'b010;
      cyc(1'b1);
      chk("post-rst fetch", int'({mem_req, bus_err, illegal}), 4);
      cyc(1'b0);
      cyc(1'b1);
      chk("ready ignored in MEMADR", int'(strb), 0);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0);
         chk("timeout waiting req", int'({mem_req, mem_we, bus_err, retire}), 12);
      end
      cyc(1'b0);
      chk("timeout bus_err", int'(bus_err), 1);
      chk("timeout req dropped", int'(mem_req), 0);
      cyc(1'b1);
      chk("timeout trap holds", int'({strb, bus_err}), 1);
      apply_reset();
      cyc(1'b0);
      chk("timeout rst resumes fetch", int'({mem_req, bus_err}), 2);

      // Reset mid-load: apply_reset checks mem_req drops with no retire or write.
      opcode = 7'h03;
      cyc(1'b1);
      cyc(1'b0);
      cyc(1'b0);
      cyc(1'b0);
      chk("midload mem_req", int'(mem_req), 1);
      apply_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
